// File: rtl/countdown_core.sv
// countdown_core: MM:SS BCD countdown timer with per-digit load, run/pause and expiry flag
module countdown_core #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       enable_A,
   input  logic       enable_B,
   input  logic       enable_C,
   input  logic       enable_D,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] C,
   input  logic [3:0] D,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       running,
   output logic       done,
   output logic       tick
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state;
   logic [PW-1:0] pre;
   logic          any_load, is_zero, dec_zero;
   logic          b0, b1, b2;
   logic [3:0]    d_mt, d_mu, d_st, d_su;

   // Ripple-borrow decrement of the current value and zero detection
   always_comb begin
      any_load = enable_A | enable_B | enable_C | enable_D;
      is_zero  = {min_tens, min_units, sec_tens, sec_units} == 16'h0000;
      b0       = sec_units == 4'd0;
      b1       = b0 && sec_tens == 4'd0;
      b2       = b1 && min_units == 4'd0;
      d_su     = b0 ? 4'd9 : sec_units - 4'd1;
      d_st     = b0 ? (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1) : sec_tens;
      d_mu     = b1 ? (min_units == 4'd0 ? 4'd9 : min_units - 4'd1) : min_units;
      d_mt     = b2 ? min_tens - 4'd1 : min_tens;
      dec_zero = {d_mt, d_mu, d_st, d_su} == 16'h0000;
   end

   // Load has priority over everything; otherwise the FSM runs the prescaler and applies steps
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pre       <= '0;
         min_tens  <= 4'd0;
         min_units <= 4'd0;
         sec_tens  <= 4'd0;
         sec_units <= 4'd0;
         running   <= 1'b0;
         done      <= 1'b0;
         tick      <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (any_load) begin
            if (enable_A) min_tens  <= A > 4'd9 ? 4'd9 : A;
            if (enable_B) min_units <= B > 4'd9 ? 4'd9 : B;
            if (enable_C) sec_tens  <= C > 4'd5 ? 4'd5 : C;
            if (enable_D) sec_units <= D > 4'd9 ? 4'd9 : D;
            state   <= IDLE;
            pre     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
         end else begin
            case (state)
               IDLE: if (run && !is_zero) begin
                  state   <= RUN;
                  pre     <= '0;
                  running <= 1'b1;
               end
               RUN: if (!run) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (pre == LAST) begin
                  pre <= '0;
                  if (!is_zero) begin
                     min_tens  <= d_mt;
                     min_units <= d_mu;
                     sec_tens  <= d_st;
                     sec_units <= d_su;
                     tick      <= 1'b1;
                  end
                  if (is_zero || dec_zero) begin
                     state   <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  pre <= pre + 1'b1;
               end
               PAUSE: if (run) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
               DONE: if (!run) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
